// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO multiply/divide unit: 2-cycle multiply, 33-cycle restoring divide
module muldiv_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_value,
    input  logic [31:0] rt_value,
    input  logic        read_req,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        divide_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    state_t      state;
    logic [4:0]  count;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        is_signed;
    logic        neg_quo;
    logic        neg_rem;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [63:0] product;

    logic        accept;
    logic        op_signed;
    logic [31:0] rs_abs;
    logic [31:0] rt_abs;
    logic [65:0] prod_wide;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign busy   = (state != IDLE);
    assign stall  = busy & (start | read_req);
    assign accept = start & (state == IDLE) & ~flush & (op <= OP_MTLO);

    assign op_signed = ~op[0];
    assign rs_abs    = (op_signed && rs_value[31]) ? (32'd0 - rs_value) : rs_value;
    assign rt_abs    = (op_signed && rt_value[31]) ? (32'd0 - rt_value) : rt_value;

    // One extra sign/zero bit per operand lets a single signed multiplier serve mult and multu
    assign prod_wide = $signed({is_signed & opa[31], opa}) * $signed({is_signed & opb[31], opb});

    // Restoring step: shift in the next dividend bit, keep the difference only if it did not borrow
    assign shifted = {rem, quo[31]};
    assign diff    = shifted - {1'b0, opb};

    assign quo_fix = neg_quo ? (32'd0 - quo) : quo;
    assign rem_fix = neg_rem ? (32'd0 - rem) : rem;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            count       <= 5'd0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            done        <= 1'b0;
            divide_zero <= 1'b0;
            opa         <= 32'd0;
            opb         <= 32'd0;
            is_signed   <= 1'b0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
            quo         <= 32'd0;
            rem         <= 32'd0;
            product     <= 64'd0;
        end else begin
            done        <= 1'b0;
            divide_zero <= 1'b0;
            if (flush) begin
                state <= IDLE;
                count <= 5'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            case (op)
                                OP_MTHI: begin
                                    hi   <= rs_value;
                                    done <= 1'b1;
                                end
                                OP_MTLO: begin
                                    lo   <= rs_value;
                                    done <= 1'b1;
                                end
                                OP_MULT, OP_MULTU: begin
                                    opa       <= rs_value;
                                    opb       <= rt_value;
                                    is_signed <= op_signed;
                                    count     <= 5'd0;
                                    state     <= MUL;
                                end
                                OP_DIV, OP_DIVU: begin
                                    if (rt_value == 32'd0) begin
                                        done        <= 1'b1;
                                        divide_zero <= 1'b1;
                                    end else begin
                                        quo     <= rs_abs;
                                        rem     <= 32'd0;
                                        opb     <= rt_abs;
                                        neg_quo <= op_signed & (rs_value[31] ^ rt_value[31]);
                                        neg_rem <= op_signed & rs_value[31];
                                        count   <= 5'd0;
                                        state   <= DIV;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    MUL: begin
                        if (count == 5'd0) begin
                            product <= prod_wide[63:0];
                            count   <= 5'd1;
                        end else begin
                            {hi, lo} <= product;
                            count    <= 5'd0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                    DIV: begin
                        if (!diff[32]) begin
                            rem <= diff[31:0];
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= shifted[31:0];
                            quo <= {quo[30:0], 1'b0};
                        end
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            state <= FIN;
                        end
                    end
                    FIN: begin
                        lo    <= quo_fix;
                        hi    <= rem_fix;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have the port `clock`, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 The block SHALL have the port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port `start`, input, 1 bit: HI/LO-writing instruction valid in EX.
REQ-004 The block SHALL have the port `op`, input, 3 bits: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110 and 111 are ignored.
REQ-005 The block SHALL have the port `rs_value`, input, 32 bits: operand A (forwarded rs); it is also the mthi/mtlo source.
REQ-006 The block SHALL have the port `rt_value`, input, 32 bits: operand B (forwarded rt); it is the divisor.
REQ-007 The block SHALL have the port `read_req`, input, 1 bit: mfhi or mflo in EX.
REQ-008 The block SHALL have the port `flush`, input, 1 bit: exception or branch cancel of the in-flight operation.
REQ-009 The block SHALL have the port `busy`, output, 1 bit: asserted whenever the state is not IDLE.
REQ-010 The block SHALL have the port `stall`, output, 1 bit: equal to busy & (start | read_req); it freezes IF/ID/EX.
REQ-011 The block SHALL have the port `done`, output, 1 bit: one-cycle registered pulse when an operation completes.
REQ-012 The block SHALL have the port `divide_zero`, output, 1 bit: one-cycle pulse coincident with done, for div/divu with a zero divisor.
REQ-013 The block SHALL have the port `hi`, output, 32 bits: architectural HI register.
REQ-014 The block SHALL have the port `lo`, output, 32 bits: architectural LO register.

Function
REQ-015 The state machine SHALL have the states IDLE, MUL, DIV and FIN, and SHALL have no other states.
REQ-016 An operation SHALL be accepted only at an edge where start=1, state=IDLE, flush=0 and op is legal; start while busy SHALL be ignored, because upstream holds start via stall.
REQ-017 An accepted mthi SHALL set hi=rs_value at the accept edge, and an accepted mtlo SHALL set lo=rs_value at the accept edge; in both cases done=1 in the following cycle and busy SHALL never assert.
REQ-018 An accepted mult or multu SHALL enter MUL for exactly 2 cycles; at the second edge after acceptance {hi,lo} SHALL take the 64-bit product and the state SHALL return to IDLE.
REQ-019 The multu product SHALL be unsigned 32x32, and the mult product SHALL be two's-complement 32x32 with a full 64-bit result.
REQ-020 An accepted div or divu with rt_value != 0 SHALL latch the operand magnitudes (absolute values for div) and enter DIV.
REQ-021 DIV SHALL perform one restoring shift-subtract step per cycle for 32 cycles, driven by a 5-bit counter; after the 32nd step the state SHALL go to FIN.
REQ-022 FIN SHALL last 1 cycle and SHALL apply the sign fix (quotient negated if the operand signs differ, remainder takes the sign of the dividend), then write lo=quotient and hi=remainder at the FIN exit edge and return to IDLE.
REQ-023 Division latency SHALL be 33 cycles of busy and done SHALL assert in the cycle after the write; mult latency SHALL be 2 busy cycles.
REQ-024 For div 0x80000000 / 0xFFFFFFFF the block SHALL produce lo=0x80000000 and hi=0, with no other signalling.
REQ-025 An accepted div or divu with rt_value == 0 SHALL NOT change state; done=1 and divide_zero=1 in the next cycle, and hi and lo SHALL be unchanged.
REQ-026 done and divide_zero SHALL be 0 in all cycles other than those stated in REQ-017, REQ-023 and REQ-025.
REQ-027 The hi and lo outputs SHALL be direct register outputs and SHALL hold their values while busy; a value read by mfhi/mflo is always committed.
REQ-028 flush=1 at any edge SHALL force the state to IDLE and clear the counter, with no write to hi/lo and no done; flush SHALL win over a simultaneous start and over a simultaneous FIN write.
REQ-029 flush with start in IDLE SHALL mean the operation is not accepted; for mthi/mtlo this means no write.
REQ-030 stall SHALL be combinational from the current state and inputs, with no register in the path.

Reset
REQ-031 reset=1 at an edge SHALL set state=IDLE, counter=0, hi=0, lo=0, done=0 and divide_zero=0, with busy=0 and stall=0 in the next cycle.
REQ-032 reset SHALL have priority over flush and start, and a reset mid-division SHALL abort the operation with no write.

Verification
REQ-033 The bench SHALL drive mult with rs=0xFFFFFFFD and rt=5, and SHALL check busy for 2 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulse.
REQ-034 The bench SHALL drive multu with rs=0xFFFFFFFF and rt=2, and SHALL check hi=0x00000001, lo=0xFFFFFFFE.
REQ-035 The bench SHALL drive div with rs=0xFFFFFFF9 (-7) and rt=2, and SHALL check busy for 33 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF, done at cycle 34.
REQ-036 The bench SHALL preset hi=0x11 and lo=0x22 via mthi/mtlo, then drive divu with rs=7 and rt=0, and SHALL check done=1, divide_zero=1, hi=0x11, lo=0x22, busy never 1.
REQ-037 The bench SHALL drive divu 100/7 with read_req=1 in the following cycle, and SHALL check stall=1 for 33 cycles, then lo=14, hi=2, stall=0.
REQ-038 The bench SHALL drive div, raise flush at busy cycle 10, and SHALL check IDLE next cycle, hi/lo unchanged, no done; then SHALL assert reset mid-mult and check hi=lo=0 with done never asserted.
